// File: rtl/ahb_cmd_sequencer.sv
// ahb_cmd_sequencer
//   Fetches instruction words from a synchronous-read instruction memory,
//   decodes them into AHB command fields and hands each command to the AHB
//   master engine over a valid/ready handshake.
//
// Ports
//   hclk        clock
//   resetn      asynchronous active-low reset
//   start       begin program at pc 0 (sampled in IDLE only)
//   abort       synchronous return to IDLE, beats everything but reset
//   imem_addr   instruction memory address (= pc)
//   imem_rdata  instruction word, valid one cycle after imem_addr is sampled
//   cmd_valid   command fields valid
//   cmd_ready   master engine accepts the command
//   cmd_data    decoded data
//   cmd_addr    decoded address
//   cmd_burst   decoded HBURST code
//   cmd_wr      decoded write (1) / read (0)
//   busy        sequencer not idle
//   done        one-cycle pulse on program completion
//   cmd_count   commands accepted since the last start, saturating
//
// Instruction word layout, LSB to MSB:
//   data[DATA_W], addr[ADDR_W], burst[3], wr[1], last[1]
module ahb_cmd_sequencer #(
   parameter  int unsigned DATA_W   = 8,
   parameter  int unsigned ADDR_W   = 11,
   parameter  int unsigned PC_W     = 10,
   parameter  int unsigned PROG_LEN = 1024,
   parameter  bit          LOOP_EN  = 1'b0,
   localparam int unsigned INSTR_W  = DATA_W + ADDR_W + 5
) (
   input  logic               hclk,
   input  logic               resetn,
   input  logic               start,
   input  logic               abort,
   output logic [PC_W-1:0]    imem_addr,
   input  logic [INSTR_W-1:0] imem_rdata,
   output logic               cmd_valid,
   input  logic               cmd_ready,
   output logic [DATA_W-1:0]  cmd_data,
   output logic [ADDR_W-1:0]  cmd_addr,
   output logic [2:0]         cmd_burst,
   output logic               cmd_wr,
   output logic               busy,
   output logic               done,
   output logic [PC_W:0]      cmd_count
);

   localparam int unsigned CNT_W = PC_W + 1;
   localparam logic [PC_W-1:0] LAST_PC = PC_W'(PROG_LEN - 1);

   // Field offsets inside the instruction word
   localparam int unsigned A_LSB = DATA_W;
   localparam int unsigned B_LSB = DATA_W + ADDR_W;
   localparam int unsigned W_BIT = B_LSB + 3;
   localparam int unsigned L_BIT = W_BIT + 1;

   typedef enum logic [2:0] {
      IDLE,
      FETCH,
      WAIT,
      VALID,
      DONE
   } state_t;

   state_t            state, state_d;
   logic [PC_W-1:0]   pc, pc_d;
   logic [CNT_W-1:0]  count, count_d;
   logic              last_q;
   logic              load;
   logic              end_prog;

   // All outputs are decoded straight from flops, so they stay glitch-free
   // and clear immediately on an asynchronous reset.
   assign imem_addr = pc;
   assign cmd_valid = (state == VALID);
   assign busy      = (state != IDLE);
   assign done      = (state == DONE);
   assign cmd_count = count;

   assign end_prog  = last_q || (pc == LAST_PC);

   always_ff @(posedge hclk or negedge resetn) begin
      if (!resetn) begin
         state     <= IDLE;
         pc        <= '0;
         count     <= '0;
         cmd_data  <= '0;
         cmd_addr  <= '0;
         cmd_burst <= '0;
         cmd_wr    <= 1'b0;
         last_q    <= 1'b0;
      end else begin
         state <= state_d;
         pc    <= pc_d;
         count <= count_d;
         if (load) begin
            cmd_data  <= imem_rdata[DATA_W-1:0];
            cmd_addr  <= imem_rdata[A_LSB +: ADDR_W];
            cmd_burst <= imem_rdata[B_LSB +: 3];
            cmd_wr    <= imem_rdata[W_BIT];
            last_q    <= imem_rdata[L_BIT];
         end
      end
   end

   always_comb begin
      state_d = state;
      pc_d    = pc;
      count_d = count;
      load    = 1'b0;
      if (abort) begin
         // Abort wins even over a simultaneous handshake, so the pending
         // command is dropped without being counted.
         state_d = IDLE;
         pc_d    = '0;
      end else begin
         case (state)
            IDLE: begin
               pc_d = '0;
               if (start) begin
                  count_d = '0;
                  state_d = FETCH;
               end
            end
            FETCH: state_d = WAIT;
            WAIT: begin
               load    = 1'b1;
               state_d = VALID;
            end
            VALID: begin
               if (cmd_ready) begin
                  if (count != '1) begin
                     count_d = count + CNT_W'(1);
                  end
                  if (end_prog) begin
                     if (LOOP_EN) begin
                        pc_d    = '0;
                        state_d = FETCH;
                     end else begin
                        state_d = DONE;
                     end
                  end else begin
                     pc_d    = pc + PC_W'(1);
                     state_d = FETCH;
                  end
               end
            end
            DONE: begin
               pc_d    = '0;
               state_d = IDLE;
            end
            default: begin
               pc_d    = '0;
               state_d = IDLE;
            end
         endcase
      end
   end

endmodule

// File: tb/tb_ahb_cmd_sequencer.sv
// tb_ahb_cmd_sequencer
//   Directed bench for ahb_cmd_sequencer. Two instances share one
//   instruction memory image: u_dut (PROG_LEN=4, LOOP_EN=0) and
//   u_loop (PROG_LEN=4, LOOP_EN=1).
module tb_ahb_cmd_sequencer;

   localparam int unsigned DATA_W  = 8;
   localparam int unsigned ADDR_W  = 11;
   localparam int unsigned PC_W    = 10;
   localparam int unsigned INSTR_W = DATA_W + ADDR_W + 5;

   logic               hclk = 1'b0;
   logic               resetn;

   // main instance
   logic               start, abort, cmd_ready;
   logic [PC_W-1:0]    imem_addr;
   logic [INSTR_W-1:0] imem_rdata;
   logic               cmd_valid, cmd_wr, busy, done;
   logic [DATA_W-1:0]  cmd_data;
   logic [ADDR_W-1:0]  cmd_addr;
   logic [2:0]         cmd_burst;
   logic [PC_W:0]      cmd_count;

   // looping instance
   logic               start_l, abort_l, ready_l;
   logic [PC_W-1:0]    imem_addr_l;
   logic [INSTR_W-1:0] imem_rdata_l;
   logic               cmd_valid_l, cmd_wr_l, busy_l, done_l;
   logic [DATA_W-1:0]  cmd_data_l;
   logic [ADDR_W-1:0]  cmd_addr_l;
   logic [2:0]         cmd_burst_l;
   logic [PC_W:0]      cmd_count_l;

   int unsigned errors = 0;
   int unsigned checks = 0;
   logic        done_l_seen = 1'b0;

   // Program words
   logic [DATA_W-1:0]  w_data  [4] = '{8'hA5, 8'h3C, 8'h0F, 8'h81};
   logic [ADDR_W-1:0]  w_addr  [4] = '{11'h123, 11'h7FF, 11'h001, 11'h400};
   logic [2:0]         w_burst [4] = '{3'd3, 3'd0, 3'd7, 3'd5};
   logic               w_wr    [4] = '{1'b1, 1'b0, 1'b1, 1'b0};
   logic               w_last  [4] = '{1'b0, 1'b0, 1'b1, 1'b0};
   logic [INSTR_W-1:0] mem     [4];

   always #5 hclk = ~hclk;

   always_comb begin
      for (int i = 0; i < 4; i++) begin
         mem[i] = {w_last[i], w_wr[i], w_burst[i], w_addr[i], w_data[i]};
      end
   end

   always @(posedge hclk) begin
      imem_rdata   <= mem[imem_addr[1:0]];
      imem_rdata_l <= mem[imem_addr_l[1:0]];
      if (done_l) done_l_seen <= 1'b1;
   end

   ahb_cmd_sequencer #(
      .DATA_W(DATA_W), .ADDR_W(ADDR_W), .PC_W(PC_W),
      .PROG_LEN(4), .LOOP_EN(1'b0)
   ) u_dut (
      .hclk(hclk), .resetn(resetn), .start(start), .abort(abort),
      .imem_addr(imem_addr), .imem_rdata(imem_rdata),
      .cmd_valid(cmd_valid), .cmd_ready(cmd_ready),
      .cmd_data(cmd_data), .cmd_addr(cmd_addr), .cmd_burst(cmd_burst),
      .cmd_wr(cmd_wr), .busy(busy), .done(done), .cmd_count(cmd_count)
   );

   ahb_cmd_sequencer #(
      .DATA_W(DATA_W), .ADDR_W(ADDR_W), .PC_W(PC_W),
      .PROG_LEN(4), .LOOP_EN(1'b1)
   ) u_loop (
      .hclk(hclk), .resetn(resetn), .start(start_l), .abort(abort_l),
      .imem_addr(imem_addr_l), .imem_rdata(imem_rdata_l),
      .cmd_valid(cmd_valid_l), .cmd_ready(ready_l),
      .cmd_data(cmd_data_l), .cmd_addr(cmd_addr_l), .cmd_burst(cmd_burst_l),
      .cmd_wr(cmd_wr_l), .busy(busy_l), .done(done_l), .cmd_count(cmd_count_l)
   );

   task automatic check_eq(input string tag, input logic [31:0] act,
                           input logic [31:0] exp);
      checks++;
      if (act !== exp) begin
         errors++;
         $display("FAIL %s: got 0x%0h expected 0x%0h", tag, act, exp);
      end
   endtask

   task automatic tick();
      @(posedge hclk);
      #1;
   endtask

   function automatic logic [31:0] exp_fields(input int k);
      return 32'({w_data[k], w_addr[k], w_burst[k], w_wr[k]});
   endfunction

   function automatic logic [31:0] dut_fields();
      return 32'({cmd_data, cmd_addr, cmd_burst, cmd_wr});
   endfunction

   initial begin
      resetn = 1'b0; start = 1'b0; abort = 1'b0; cmd_ready = 1'b0;
      start_l = 1'b0; abort_l = 1'b0; ready_l = 1'b1;
      #1;
      check_eq("rst_busy", busy, 0);
      check_eq("rst_valid", cmd_valid, 0);
      check_eq("rst_done", done, 0);
      check_eq("rst_addr", imem_addr, 0);
      check_eq("rst_fields", dut_fields(), 0);
      check_eq("rst_count", cmd_count, 0);
      #11 resetn = 1'b1;
      tick();

      // 3-word program (last bit on word 2), ready tied high
      cmd_ready = 1'b1;
      start = 1'b1;
      tick();                               // cycle 1: FETCH
      start = 1'b0;
      check_eq("p3_c1_busy", busy, 1);
      check_eq("p3_c1_valid", cmd_valid, 0);
      for (int k = 0; k < 3; k++) begin
         tick();                            // WAIT
         check_eq("p3_wait_valid", cmd_valid, 0);
         tick();                            // VALID at cycles 3, 6, 9
         check_eq("p3_valid", cmd_valid, 1);
         check_eq("p3_pc", imem_addr, k);
         check_eq("p3_fields", dut_fields(), exp_fields(k));
         check_eq("p3_count", cmd_count, k);
         check_eq("p3_nodone", done, 0);
         tick();
      end
      // cycle 10
      check_eq("p3_done", done, 1);
      check_eq("p3_count_end", cmd_count, 3);
      check_eq("p3_busy10", busy, 1);
      tick();                               // cycle 11
      check_eq("p3_done11", done, 0);
      check_eq("p3_busy11", busy, 0);
      check_eq("p3_hold_fields", dut_fields(), exp_fields(2));

      // Backpressure on word 0
      cmd_ready = 1'b0;
      start = 1'b1;
      tick();
      start = 1'b0;
      tick();
      tick();                               // VALID
      for (int i = 0; i < 5; i++) begin
         check_eq("bp_valid", cmd_valid, 1);
         check_eq("bp_fields", dut_fields(), 32'h0052_4F3 >> 0 == 0 ? 0 : exp_fields(0));
         check_eq("bp_count", cmd_count, 0);
         tick();
      end
      cmd_ready = 1'b1;
      tick();                               // accepted
      check_eq("bp_count1", cmd_count, 1);
      check_eq("bp_valid_lo", cmd_valid, 0);
      check_eq("bp_pc1", imem_addr, 1);
      cmd_ready = 1'b0;
      tick();
      tick();                               // VALID word 1
      check_eq("ab_pre_fields", dut_fields(), exp_fields(1));
      // Abort together with ready
      abort = 1'b1;
      cmd_ready = 1'b1;
      tick();
      abort = 1'b0;
      cmd_ready = 1'b0;
      check_eq("ab_busy", busy, 0);
      check_eq("ab_valid", cmd_valid, 0);
      check_eq("ab_count", cmd_count, 1);
      check_eq("ab_done", done, 0);
      check_eq("ab_pc", imem_addr, 0);
      tick();
      check_eq("ab_done2", done, 0);
      check_eq("ab_idle", busy, 0);

      // Restart with start held high throughout
      start = 1'b1;
      tick();
      check_eq("rs_count0", cmd_count, 0);
      check_eq("rs_pc0", imem_addr, 0);
      tick();
      tick();
      tick();                               // still VALID, ready low
      check_eq("sh_valid", cmd_valid, 1);
      check_eq("sh_pc", imem_addr, 0);
      cmd_ready = 1'b1;
      tick();
      check_eq("sh_pc1", imem_addr, 1);
      check_eq("sh_count1", cmd_count, 1);
      start = 1'b0;
      cmd_ready = 1'b0;
      abort = 1'b1;
      tick();
      abort = 1'b0;

      // Start and abort together in IDLE
      start = 1'b1;
      abort = 1'b1;
      tick();
      start = 1'b0;
      abort = 1'b0;
      check_eq("sa_busy", busy, 0);
      tick();
      check_eq("sa_busy2", busy, 0);

      // PROG_LEN end: no last bits, four commands then done
      w_last[2] = 1'b0;
      cmd_ready = 1'b1;
      start = 1'b1;
      tick();
      start = 1'b0;
      for (int k = 0; k < 4; k++) begin
         tick();
         tick();
         check_eq("pl_valid", cmd_valid, 1);
         check_eq("pl_pc", imem_addr, k);
         check_eq("pl_fields", dut_fields(), exp_fields(k));
         tick();
      end
      check_eq("pl_done", done, 1);
      check_eq("pl_count", cmd_count, 4);
      tick();
      check_eq("pl_busy", busy, 0);

      // Async reset mid-WAIT of the second command
      start = 1'b1;
      tick();
      start = 1'b0;
      tick();
      tick();
      tick();                               // FETCH pc 1, count 1
      tick();                               // WAIT
      check_eq("rw_pre_count", cmd_count, 1);
      resetn = 1'b0;
      #1;
      check_eq("rw_busy", busy, 0);
      check_eq("rw_valid", cmd_valid, 0);
      check_eq("rw_addr", imem_addr, 0);
      check_eq("rw_fields", dut_fields(), 0);
      check_eq("rw_count", cmd_count, 0);
      check_eq("rw_done", done, 0);
      #3 resetn = 1'b1;
      for (int i = 0; i < 4; i++) tick();
      check_eq("rw_after_busy", busy, 0);
      check_eq("rw_after_valid", cmd_valid, 0);

      // Looping instance: pc wraps 3 -> 0, no done, count keeps rising
      start_l = 1'b1;
      tick();
      start_l = 1'b0;
      for (int k = 0; k < 6; k++) begin
         tick();
         tick();
         check_eq("lp_valid", cmd_valid_l, 1);
         check_eq("lp_pc", imem_addr_l, k % 4);
         tick();
      end
      check_eq("lp_count6", cmd_count_l, 6);
      for (int i = 0; i < 8000 && cmd_count_l != 11'h7FF; i++) tick();
      check_eq("lp_sat", cmd_count_l, 11'h7FF);
      for (int i = 0; i < 30; i++) tick();
      check_eq("lp_sat_hold", cmd_count_l, 11'h7FF);
      check_eq("lp_busy", busy_l, 1);
      check_eq("lp_nodone", done_l_seen, 0);

      $display("Result: errors=%0d of %0d checks", errors, checks);
      $finish;
   end

endmodule

// File: doc/ahb_cmd_sequencer.md
# ahb_cmd_sequencer

Parametrised command sequencer for the AHB master. It fetches instruction words from a synchronous-read instruction memory and decodes each into data, address, burst-type and write fields. It presents each command to the AHB master engine over a valid/ready handshake, stalling while the engine is busy. It also supports start/abort control, end-of-program detection via a last bit or program length, optional looping, and an accepted-command counter.

## Interface
- DATA_W, 8, data field width
- ADDR_W, 11, address field width
- PC_W, 10, program counter / instruction memory address width
- PROG_LEN, 1024, number of valid instruction words, 1..2^PC_W
- LOOP_EN, 0, 1 = restart at pc 0 after the last command instead of finishing
- INSTR_W (localparam) = DATA_W+ADDR_W+5; word layout LSB→MSB: data[DATA_W], addr[ADDR_W], burst[3], wr[1], last[1]

- hclk  in  1  clock
- resetn  in  1  asynchronous, active-low reset
- start  in  1  begin program at pc 0; sampled only in IDLE
- abort  in  1  synchronous abort to IDLE; has priority over everything except reset
- imem_addr  out  PC_W  instruction memory address, equal to pc
- imem_rdata  in  INSTR_W  instruction word, valid 1 cycle after the address is sampled
- cmd_valid  out  1  command fields valid
- cmd_ready  in  1  master engine accepts the command
- cmd_data  out  DATA_W  decoded data
- cmd_addr  out  ADDR_W  decoded address
- cmd_burst  out  3  decoded HBURST code
- cmd_wr  out  1  decoded write (1) / read (0)
- busy  out  1  state ≠ IDLE
- done  out  1  one-cycle pulse when the program completes
- cmd_count  out  PC_W+1  commands accepted since the last start; saturates at all-ones

## Operation
- States: IDLE, FETCH, WAIT, VALID, DONE. Registered outputs; state, pc and fields are flops.
- IDLE: pc=0, cmd_valid=0. On start=1 (and abort=0): cmd_count←0, go to FETCH.
- FETCH: imem_addr=pc is presented and the memory samples it at the end of the cycle. Go to WAIT.
- WAIT: imem_rdata is valid. Capture data, addr, burst, wr and last into registers. Go to VALID.
- VALID: cmd_valid=1. Hold all cmd_* fields stable while cmd_ready=0. Acceptance occurs when cmd_valid=1 and cmd_ready=1. On acceptance, cmd_count increments (saturating).
- After acceptance, end of program is reached when last=1 or pc==PROG_LEN-1:
  - End with LOOP_EN=0: go to DONE.
  - End with LOOP_EN=1: pc←0, go to FETCH.
  - Otherwise: pc←pc+1, go to FETCH.
- DONE: done=1 for exactly this cycle, pc←0, then IDLE.
- abort=1 in any state: next state IDLE, pc←0, cmd_valid←0. No done pulse is produced and cmd_count is held. A command in VALID with abort and cmd_ready both high is NOT counted.
- start outside IDLE is ignored. start and abort together in IDLE: remain in IDLE.
- cmd_* fields keep their last captured value after acceptance. Only reset clears them.
- Reset (async): state=IDLE, pc=0, imem_addr=0, cmd_valid=0, all cmd_* fields=0, busy=0, done=0, cmd_count=0.

## Timing
- Start sampled at edge E0 → FETCH in cycle 1 → WAIT in cycle 2 → cmd_valid=1 from cycle 3.
- Throughput is 1 command per 3 cycles with cmd_ready tied high: accept edge → FETCH → WAIT → VALID.
- Last command accepted at edge E → done=1 in cycle E+1 → busy=0 from cycle E+2.
- With LOOP_EN=1, no done is ever produced. pc wraps from PROG_LEN-1 (or a last word) to 0.
- cmd_count updates on the accept edge and is visible the following cycle.
- Reset deassertion mid-program: resumes in IDLE. A new start is required.

## Test plan
- Program of 3 words (last bit set on word 2), cmd_ready=1, start pulse → cmd_valid at cycles 3, 6 and 9 with correctly decoded fields, done pulse at cycle 10, cmd_count=3, busy=0 at cycle 11.
- Backpressure: hold cmd_ready=0 for 5 cycles on word 0 (data 0xA5, addr 0x123, burst 3, wr 1) → cmd_valid stays high with fields stable; a single acceptance is counted when ready rises.
- PROG_LEN=4, no last bits, LOOP_EN=0 → 4 commands then done. Same program with LOOP_EN=1 → pc sequence 0,1,2,3,0,1…, no done, cmd_count keeps incrementing.
- Abort asserted in VALID together with cmd_ready=1 → IDLE next cycle, cmd_valid=0, count not incremented, no done. A new start restarts at pc 0 with cmd_count=0.
- Start held high during VALID has no effect. Start and abort together in IDLE → stays IDLE.
- Async reset asserted mid-WAIT → all outputs 0 immediately. After release, no activity until start.
